bcd_countdown: RTL
==================

Name: bcd_countdown

Overview:
- Multi-digit BCD down-counter (countdown timer). It is the descending counterpart of the team's decade up-counter: each digit counts 9..0 with borrow ripple instead of 0..9 with carry.
- Loaded with a BCD start value and decremented on enable ticks. Pulses done on reaching zero; optionally auto-reloads.
- Used as a programmable interval/timeout source for control logic.

Parameters:
- DIGITS, 4, number of BCD digits; q width = 4*DIGITS.
- AUTO_RELOAD, 0, 1 = reload the last loaded value after reaching zero; 0 = stop at zero.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- load  input  1  load request, sampled on posedge.
- load_val  input  4*DIGITS  BCD start value; nibble i = digit i, nibble 0 = ones.
- ena  input  1  count tick enable.
- q  output  4*DIGITS  current BCD count, registered.
- running  output  1  high while in RUN state.
- done  output  1  one-cycle pulse, high in the cycle q first shows zero after a count.
- load_err  output  1  one-cycle pulse, high after a rejected load.

Behaviour:
- Reset: q=0, running=0, done=0, load_err=0, internal reload register=0, state=IDLE. Reset overrides load and ena in the same cycle.
- Priority per cycle: reset > load > ena decrement.
- done and load_err default to 0 every cycle unless set by the rules below.
- Load validation: the load is rejected if any nibble of load_val is >9.
  - Rejected load: load_err=1 next cycle; q, state and reload register unchanged; any pending ena in that cycle is also ignored.
- Valid load:
  - q<=load_val and reload<=load_val.
  - State goes to RUN if load_val!=0, else IDLE. running follows state.
  - done is not asserted by a load, including a load of zero.
  - A load during RUN restarts the count. ena in the same cycle is ignored.
- IDLE: ena has no effect; q holds.
- RUN, ena=0: q holds.
- RUN, ena=1, q!=0: BCD decrement.
  - Digit 0 decrements every tick.
  - Digit i>0 decrements only when all lower digits are 0, i.e. borrow ripples.
  - A digit at 0 that receives a borrow wraps to 9.
  - Example: 1000 -> 0999.
- RUN, ena=1, q==1 (value one): q<=0 and done<=1, so done is high in the same cycle q first reads 0.
  - AUTO_RELOAD=0: state goes to IDLE; running=0 from that cycle.
  - AUTO_RELOAD=1: state stays RUN.
- RUN, ena=1, q==0: reachable only with AUTO_RELOAD=1. q<=reload, no done pulse.
  - Reload period is (reload+1) enabled ticks. Example: reload=9 gives 9,8,...,0,9, i.e. a 10-state period.
- Latency: one cycle from a sampled load/ena/reset to the visible q change.
- Width: decrement is per-nibble BCD, never binary on the full vector. q nibbles are always in 0..9.

Decomposition:
- Shared package (bcd_pkg):
  - state enum {IDLE, RUN}.
  - BCD_MAX = 4'd9.
  - function bcd_valid(vector) returning 1 if all nibbles are ≤9.
- Sub-module bcd_down_digit, instantiated DIGITS times:
  - Inputs: borrow_in, load, load_digit.
  - Outputs: 4-bit digit, borrow_out (asserted when digit==0 and borrow_in).
- Top: state machine, validation, reload register, done/load_err generation.

Test Plan:
- Reset then load 0x0003, ena held high -> q: 0003, 0002, 0001, 0000. done=1 only in the 0000 cycle; running drops the same cycle; q stays 0000 for ≥5 further ena ticks.
- Load 0x1000, ena high for 3 ticks -> q: 1000, 0999, 0998, 0997. Checks multi-digit borrow and 0->9 wrap.
- Load 0x00A5 while q=0042 -> load_err pulses one cycle; q stays 0042; running unchanged; ena asserted in the same cycle causes no decrement.
- AUTO_RELOAD=1, load 0x0009, ena continuous for 25 ticks -> q cycles 9..0 with period 10. done pulses every 10th tick (at each 0); running stays 1.
- Load 0x0050, ena toggled with random gaps -> q decrements only on ena=1 cycles. reset asserted mid-run -> next cycle q=0000, running=0, no done. Load 0x0000 -> IDLE, no done pulse.
- Simultaneous load 0x0007 and ena while q=0001 -> q=0007, done stays 0, running=1. Checks that load has priority over the zero-reaching decrement.

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types, constants and helpers for the BCD countdown timer.
//   state_t    : controller state (IDLE / RUN)
//   BCD_MAX    : largest legal BCD digit
//   bcd_valid  : 1 when every nibble of a (zero-extended) vector is <= 9
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Widest counter the validator handles. Narrower vectors are zero-extended
  // by the caller; a zero nibble is always legal, so extension is harmless.
  localparam int MAX_DIGITS = 16;
  localparam int BCD_VEC_W  = 4 * MAX_DIGITS;

  function automatic logic bcd_valid(input logic [BCD_VEC_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (v[4*i +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_countdown_if.sv
// -----------------------------------------------------------------------------
// bcd_countdown_if
// Control/status bundle of the BCD countdown timer.
//   load      : load request, sampled on posedge
//   load_val  : BCD start value, nibble 0 = ones digit
//   ena       : count tick enable
//   q         : current BCD count (registered)
//   running   : high while the timer is in RUN
//   done      : one-cycle pulse in the cycle q first reads zero after a count
//   load_err  : one-cycle pulse after a load with a non-BCD nibble
// master = the controlling logic, slave = the timer.
// -----------------------------------------------------------------------------
interface bcd_countdown_if #(
  parameter int DIGITS = 4
) ();

  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  ena;
  logic [4*DIGITS-1:0]   q;
  logic                  running;
  logic                  done;
  logic                  load_err;

  modport master (
    output load, load_val, ena,
    input  q, running, done, load_err
  );

  modport slave (
    input  load, load_val, ena,
    output q, running, done, load_err
  );

endinterface

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One decade of the countdown chain: counts 9..0, wrapping 0 -> 9 on a borrow.
//   clk, reset   : clock, synchronous active-high reset
//   load         : parallel load (takes priority over borrow_in)
//   load_digit   : value to load
//   borrow_in    : decrement this digit (all lower digits are at zero)
//   digit        : registered digit value, always 0..9 given legal loads
//   borrow_out   : borrow into the next higher digit (digit==0 and borrow_in)
// -----------------------------------------------------------------------------
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  // NOTE: state is written with <= so every register samples pre-edge values,
  // regardless of the order the simulator evaluates the chain of digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_digit;
    end else if (borrow_in) begin
      digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign borrow_out = borrow_in && (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown.sv
// -----------------------------------------------------------------------------
// bcd_countdown
// Multi-digit BCD down-counter used as a programmable interval/timeout source.
// Loaded with a BCD value, decremented on ena ticks while running, pulses done
// when the count reaches zero and, with AUTO_RELOAD=1, restarts from the last
// loaded value on the tick after zero (period = reload+1 ticks).
//   Parameters: DIGITS (number of BCD digits, <= bcd_pkg::MAX_DIGITS),
//               AUTO_RELOAD (1 = reload after zero, 0 = stop at zero)
//   clk    : clock, all state updates on posedge
//   reset  : synchronous, active-high; overrides load and ena
//   bus    : bcd_countdown_if.slave (load/load_val/ena in,
//            q/running/done/load_err out, all outputs registered)
// Per-cycle priority: reset > load > ena decrement.
// -----------------------------------------------------------------------------
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  bcd_countdown_if.slave   bus
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = W'(1);

  state_t         state_q, state_d;
  logic [W-1:0]   reload_q, reload_d;
  logic [W-1:0]   q_vec;
  logic [W-1:0]   digit_val;
  logic           digit_load;
  logic           dec_en;
  logic           load_ok;
  logic           q_one;
  logic           wrap;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [DIGITS:0] borrow;

  // Any load request, accepted or rejected, swallows the ena of that cycle.
  assign dec_en    = (state_q == RUN) && bus.ena && !bus.load;
  assign load_ok   = bcd_valid(BCD_VEC_W'(bus.load_val));
  assign q_one     = (q_vec == ONE);
  assign borrow[0] = dec_en;

  // A borrow out of the top digit means a tick arrived while q was zero:
  // instead of wrapping to all nines, the chain is reloaded.
  assign wrap = borrow[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (digit_load),
      .load_digit (digit_val[4*i +: 4]),
      .borrow_in  (borrow[i]),
      .digit      (q_vec[4*i +: 4]),
      .borrow_out (borrow[i+1])
    );
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the if/else tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    reload_d   = reload_q;
    digit_load = 1'b0;
    digit_val  = bus.load_val;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (bus.load) begin
      if (load_ok) begin
        digit_load = 1'b1;
        reload_d   = bus.load_val;
        state_d    = (bus.load_val != '0) ? RUN : IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (wrap) begin
      // Only reachable with auto-reload; the zero fallback keeps q legal
      // should the non-reloading variant ever get here.
      digit_load = 1'b1;
      digit_val  = AUTO_RELOAD ? reload_q : '0;
    end else if (dec_en && q_one) begin
      done_d = 1'b1;
      if (!AUTO_RELOAD) state_d = IDLE;
    end
  end

  // NOTE: the reload value is a plain register, not a memory, so it is reset
  // along with the rest of the state and a tick after zero is well defined.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      reload_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.q        = q_vec;
  assign bus.running  = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.load_err = err_q;

endmodule
